// File: rtl/ws2812_pixel_serializer.sv
// Buffers 24-bit GRB pixels in a small FIFO and serializes them onto a WS2812 one-wire line.
// Each bit is a timed high pulse followed by low fill, and each frame ends with a low latch gap.
module ws2812_pixel_serializer #(
    parameter int unsigned DEPTH        = 16,
    parameter int unsigned T0H          = 20,
    parameter int unsigned T1H          = 40,
    parameter int unsigned BIT_PERIOD   = 63,
    parameter int unsigned RESET_CYCLES = 2600
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [23:0]              pixel_data,
    input  logic                     pixel_last,
    input  logic                     pixel_valid,
    output logic                     pixel_ready,
    output logic                     one_wire,
    output logic                     busy,
    output logic                     underrun,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;
    localparam int unsigned CNT_W = $clog2(BIT_PERIOD + 1);
    localparam int unsigned LAT_W = $clog2(RESET_CYCLES + 1);

    localparam logic [CNT_W-1:0] T0H_END    = CNT_W'(T0H - 1);
    localparam logic [CNT_W-1:0] T1H_END    = CNT_W'(T1H - 1);
    localparam logic [CNT_W-1:0] PERIOD_END = CNT_W'(BIT_PERIOD - 1);
    localparam logic [LAT_W-1:0] LATCH_END  = LAT_W'(RESET_CYCLES - 1);
    localparam logic [LVL_W-1:0] FULL_LVL   = LVL_W'(DEPTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_HIGH  = 2'd1;
    localparam logic [1:0] S_LOW   = 2'd2;
    localparam logic [1:0] S_LATCH = 2'd3;

    typedef struct packed {
        logic        last;
        logic [23:0] data;
    } entry_t;

    entry_t           mem [DEPTH];
    entry_t           head;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;

    logic [1:0]       state;
    logic [1:0]       state_next;
    logic [23:0]      shift_reg;
    logic [23:0]      shift_next;
    logic [4:0]       bit_cnt;
    logic [4:0]       bit_next;
    logic             last_flag;
    logic             last_next;
    logic [CNT_W-1:0] cyc;
    logic [CNT_W-1:0] cyc_next;
    logic [CNT_W-1:0] high_end;
    logic [LAT_W-1:0] lat_cnt;
    logic [LAT_W-1:0] lat_next;
    logic             underrun_next;

    assign full        = (level == FULL_LVL);
    assign empty       = (level == '0);
    assign push        = pixel_valid & ~full;
    assign head        = mem[rd_ptr];
    assign pixel_ready = ~full;
    assign busy        = (state != S_IDLE) | ~empty;
    assign high_end    = shift_reg[23] ? T1H_END : T0H_END;

    // FIFO storage; contents need no reset since level gates every read
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= entry_t'({pixel_last, pixel_data});
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Bit sequencing: cyc spans the whole bit so the low fill ends at BIT_PERIOD
    always_comb begin
        state_next    = state;
        pop           = 1'b0;
        cyc_next      = '0;
        lat_next      = lat_cnt;
        bit_next      = bit_cnt;
        shift_next    = shift_reg;
        last_next     = last_flag;
        underrun_next = 1'b0;
        case (state)
            S_IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    state_next = S_HIGH;
                end
            end
            S_HIGH: begin
                cyc_next = cyc + 1'b1;
                if (cyc == high_end) begin
                    state_next = S_LOW;
                end
            end
            S_LOW: begin
                cyc_next = cyc + 1'b1;
                if (cyc == PERIOD_END) begin
                    cyc_next = '0;
                    if (bit_cnt != '0) begin
                        shift_next = {shift_reg[22:0], 1'b0};
                        bit_next   = bit_cnt - 1'b1;
                        state_next = S_HIGH;
                    end else if (last_flag) begin
                        lat_next   = '0;
                        state_next = S_LATCH;
                    end else if (!empty) begin
                        pop        = 1'b1;
                        state_next = S_HIGH;
                    end else begin
                        underrun_next = 1'b1;
                        lat_next      = '0;
                        state_next    = S_LATCH;
                    end
                end
            end
            S_LATCH: begin
                if (lat_cnt == LATCH_END) begin
                    state_next = S_IDLE;
                end else begin
                    lat_next = lat_cnt + 1'b1;
                end
            end
            default: state_next = S_IDLE;
        endcase
        if (pop) begin
            shift_next = head.data;
            last_next  = head.last;
            bit_next   = 5'd23;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
            last_flag <= 1'b0;
            cyc       <= '0;
            lat_cnt   <= '0;
            one_wire  <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            shift_reg <= shift_next;
            bit_cnt   <= bit_next;
            last_flag <= last_next;
            cyc       <= cyc_next;
            lat_cnt   <= lat_next;
            one_wire  <= (state == S_HIGH);
            underrun  <= underrun_next;
        end
    end

endmodule

// File: tb/tb_ws2812_pixel_serializer.sv
// Self-checking bench: decodes the one-wire waveform back into pixels and compares them
// with the words accepted at the input, plus table-driven timing vectors and corner sequences.
module tb_ws2812_pixel_serializer;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned T0H   = 2;
    localparam int unsigned T1H   = 4;
    localparam int unsigned BP    = 6;
    localparam int unsigned RC    = 10;

    logic        clock;
    logic        reset;
    logic [23:0] pixel_data;
    logic        pixel_last;
    logic        pixel_valid;
    logic        pixel_ready;
    logic        one_wire;
    logic        busy;
    logic        underrun;
    logic [2:0]  level;

    ws2812_pixel_serializer #(
        .DEPTH(DEPTH), .T0H(T0H), .T1H(T1H), .BIT_PERIOD(BP), .RESET_CYCLES(RC)
    ) dut (
        .clock(clock), .reset(reset), .pixel_data(pixel_data), .pixel_last(pixel_last),
        .pixel_valid(pixel_valid), .pixel_ready(pixel_ready), .one_wire(one_wire),
        .busy(busy), .underrun(underrun), .level(level)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int vectors    = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Reference model: accepted words in order, recovered from the line by pulse widths
    logic [23:0] exp_q[$];
    logic [23:0] bits;
    logic [23:0] exp_word;
    logic        prev;
    int run, nbits, h, pix_cnt, busy_cnt, under_cnt, high_cnt, stall_cnt, ready_bad;
    logic        have_h;
    logic [2:0]  max_level;
    time         under_time;

    initial begin
        prev = 0; run = 0; nbits = 0; have_h = 0; pix_cnt = 0; busy_cnt = 0; under_cnt = 0;
        high_cnt = 0; stall_cnt = 0; ready_bad = 0; max_level = 0; under_time = 0; bits = 0;
        forever begin
            @(negedge clock);
            if (reset) begin
                prev = 0; run = 0; nbits = 0; have_h = 0;
                exp_q.delete();
            end else begin
                if (pixel_valid && pixel_ready) exp_q.push_back(pixel_data);
                if (busy) busy_cnt++;
                if (underrun) begin
                    under_cnt++;
                    under_time = $time;
                end
                if (one_wire) high_cnt++;
                if (!pixel_ready) stall_cnt++;
                if (level > max_level) max_level = level;
                if (pixel_ready !== (level != 3'd4)) ready_bad++;
                if (one_wire == prev) begin
                    run++;
                end else if (one_wire) begin
                    if (have_h) begin
                        if (run == int'(BP) - h) begin
                            // contiguous next bit
                        end else if (run >= int'(BP) - h + int'(RC) + 1) begin
                            check("frame_gap_on_pixel_boundary", 32'(nbits), 32'd0);
                        end else begin
                            check("low_width", 32'(run), 32'(int'(BP) - h));
                        end
                    end
                    run = 1;
                end else begin
                    h = run;
                    check("high_width_legal", 32'((h == int'(T0H)) || (h == int'(T1H))), 32'd1);
                    bits = {bits[22:0], (h == int'(T1H))};
                    nbits++;
                    have_h = 1;
                    if (nbits == 24) begin
                        if (exp_q.size() == 0) begin
                            check("pixel_without_push", 32'(bits), 32'hFFFF_FFFF);
                        end else begin
                            exp_word = exp_q.pop_front();
                            check("pixel_word", 32'(bits), 32'(exp_word));
                        end
                        nbits = 0;
                        pix_cnt++;
                    end
                    run = 1;
                end
                prev = one_wire;
            end
        end
    end

    time t_acc;

    // Holds valid until the word is taken; returns just after the accepting edge
    task automatic push_hold(input logic [23:0] d, input logic l);
        logic acc;
        int n;
        acc = 0;
        n = 0;
        pixel_data  = d;
        pixel_last  = l;
        pixel_valid = 1'b1;
        while (!acc && n < 2000) begin
            @(negedge clock);
            acc = pixel_ready;
            @(posedge clock);
            t_acc = $time;
            #1;
            n++;
        end
        pixel_valid = 1'b0;
        check("push_accepted", 32'(acc), 32'd1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (busy && n < 5000);
        check("return_to_idle", 32'(busy), 32'd0);
        @(posedge clock);
        #1;
    endtask

    typedef struct {
        logic [23:0] data;
        logic        last;
        int          rise;
        int          busy_cycles;
        int          underruns;
        int          under_dt;
    } vec_t;

    vec_t vecs[4];
    int   b0, u0, p0, h0, lat;

    initial begin
        vecs[0] = '{24'hA50F00, 1'b1, 2, 1 + 24 * BP + RC, 0, 0};
        vecs[1] = '{24'hFFFFFF, 1'b1, 2, 1 + 24 * BP + RC, 0, 0};
        vecs[2] = '{24'h000001, 1'b1, 2, 1 + 24 * BP + RC, 0, 0};
        vecs[3] = '{24'h123456, 1'b0, 2, 1 + 24 * BP + RC, 1, (24 * BP + 1) * 10 + 5};

        reset = 1'b1;
        pixel_valid = 1'b0;
        pixel_data = '0;
        pixel_last = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("in_reset_one_wire", 32'(one_wire), 32'd0);
        check("in_reset_level", 32'(level), 32'd0);
        @(posedge clock);
        #1 reset = 1'b0;

        // Idle after reset
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            check("rst_one_wire", 32'(one_wire), 32'd0);
            check("rst_ready", 32'(pixel_ready), 32'd1);
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_level", 32'(level), 32'd0);
        end
        @(posedge clock);
        #1;

        // Single-pixel vectors
        for (int i = 0; i < 4; i++) begin
            wait_idle();
            repeat (3) @(posedge clock);
            #1;
            b0 = busy_cnt; u0 = under_cnt; p0 = pix_cnt;
            push_hold(vecs[i].data, vecs[i].last);
            lat = 0;
            for (int k = 0; k < 20; k++) begin
                @(negedge clock);
                if (one_wire) break;
                lat++;
            end
            check("rise_latency", 32'(lat), 32'(vecs[i].rise));
            wait_idle();
            check("busy_cycles", 32'(busy_cnt - b0), 32'(vecs[i].busy_cycles));
            check("underrun_cycles", 32'(under_cnt - u0), 32'(vecs[i].underruns));
            check("pixels_out", 32'(pix_cnt - p0), 32'd1);
            if (vecs[i].underruns != 0)
                check("underrun_time", 32'(under_time - t_acc), 32'(vecs[i].under_dt));
        end

        // Back-to-back frame of three pixels
        wait_idle();
        b0 = busy_cnt; u0 = under_cnt; p0 = pix_cnt;
        push_hold(24'hC0FFEE, 1'b0);
        push_hold(24'h00AA55, 1'b0);
        push_hold(24'h8F0F01, 1'b1);
        wait_idle();
        check("b2b_busy_cycles", 32'(busy_cnt - b0), 32'(1 + 72 * BP + RC));
        check("b2b_underrun", 32'(under_cnt - u0), 32'd0);
        check("b2b_pixels", 32'(pix_cnt - p0), 32'd3);

        // Backpressure with six words
        wait_idle();
        b0 = busy_cnt; u0 = under_cnt; p0 = pix_cnt;
        max_level = 0; stall_cnt = 0; ready_bad = 0;
        for (int i = 0; i < 6; i++) push_hold(24'h101010 * 24'(i + 1), (i == 5));
        wait_idle();
        check("bp_max_level", 32'(max_level), 32'd4);
        check("bp_stalled", 32'(stall_cnt > 0), 32'd1);
        check("bp_ready_vs_level", 32'(ready_bad), 32'd0);
        check("bp_pixels", 32'(pix_cnt - p0), 32'd6);
        check("bp_underrun", 32'(under_cnt - u0), 32'd0);
        check("bp_busy_cycles", 32'(busy_cnt - b0), 32'(1 + 6 * 24 * BP + RC));

        // Asynchronous reset in the middle of a high pulse
        wait_idle();
        push_hold(24'hFFFFFF, 1'b1);
        push_hold(24'h00FF00, 1'b1);
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            if (one_wire) break;
        end
        @(posedge clock);
        #2;
        check("pre_reset_high", 32'(one_wire), 32'd1);
        reset = 1'b1;
        #1;
        check("async_one_wire", 32'(one_wire), 32'd0);
        check("async_level", 32'(level), 32'd0);
        check("async_busy", 32'(busy), 32'd0);
        check("async_ready", 32'(pixel_ready), 32'd1);
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        h0 = high_cnt;
        repeat (300) @(negedge clock);
        check("no_stale_pixel", 32'(high_cnt - h0), 32'd0);
        check("post_reset_busy", 32'(busy), 32'd0);
        @(posedge clock);
        #1;

        // Random words, random gaps and frame ends
        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 300)) @(posedge clock);
            #1;
            push_hold(24'($urandom), ($urandom_range(0, 3) == 0));
        end
        wait_idle();
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        check("no_partial_pixel", 32'(nbits), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
